// File: rtl/result_uart_tx.sv
//----------------------------------------------------------------------------
// result_uart_tx : 8N1 serialiser for 42-bit result words (sync + 6 bytes)
// Revision 1.0
//----------------------------------------------------------------------------
`default_nettype none

module result_uart_tx #(
   parameter int         BAUD      = 8,
   parameter bit         SYNC_EN   = 1'b1,
   parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        tx_word_valid,
   input  logic [41:0] tx_word,
   output logic        tx_word_ready,
   output logic        tx_dout,
   output logic        tx_busy,
   output logic        tx_word_done
);

   localparam int             BW        = (BAUD > 1) ? $clog2(BAUD) : 1;
   localparam logic [BW-1:0]  BAUD_LAST = BW'(BAUD - 1);
   localparam logic [2:0]     LAST_BYTE = SYNC_EN ? 3'd6 : 3'd5;

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t        state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [2:0]    byte_q, byte_d;
   logic [41:0]   word_q, word_d;
   logic          dout_q, dout_d;
   logic          ready_q, ready_d;
   logic          done_q, done_d;

   logic [55:0]   w_frame;
   logic [7:0]    w_cur_byte;
   logic [2:0]    w_bit_nxt;
   logic          w_tick;

   // Unused upper bits of the frame are forced to zero so nothing undefined can reach the line.
   assign w_frame    = SYNC_EN ? {6'b0, word_q, SYNC_BYTE} : {8'h00, 6'b0, word_q};
   assign w_cur_byte = w_frame[{byte_q, 3'b000} +: 8];
   assign w_bit_nxt  = bit_q + 3'd1;
   assign w_tick     = (baud_q == BAUD_LAST);

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      byte_d  = byte_q;
      word_d  = word_q;
      dout_d  = dout_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            dout_d = 1'b1;
            if (tx_word_valid && ready_q) begin
               state_d = S_START;
               word_d  = tx_word;
               baud_d  = '0;
               bit_d   = '0;
               byte_d  = '0;
               dout_d  = 1'b0;
            end
         end
         S_START: begin
            if (w_tick) begin
               baud_d  = '0;
               state_d = S_DATA;
               dout_d  = w_cur_byte[0];
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         S_DATA: begin
            if (w_tick) begin
               baud_d = '0;
               if (bit_q == 3'd7) begin
                  state_d = S_STOP;
                  dout_d  = 1'b1;
               end else begin
                  bit_d  = w_bit_nxt;
                  dout_d = w_cur_byte[w_bit_nxt];
               end
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         S_STOP: begin
            if (w_tick) begin
               baud_d = '0;
               bit_d  = '0;
               if (byte_q == LAST_BYTE) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  byte_d  = byte_q + 3'd1;
                  state_d = S_START;
                  dout_d  = 1'b0;
               end
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
      ready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         byte_q  <= '0;
         word_q  <= '0;
         dout_q  <= 1'b1;
         ready_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         word_q  <= word_d;
         dout_q  <= dout_d;
         ready_q <= ready_d;
         done_q  <= done_d;
      end
   end

   assign tx_word_ready = ready_q;
   assign tx_dout       = dout_q;
   assign tx_busy       = (state_q != S_IDLE);
   assign tx_word_done  = done_q;

endmodule

`default_nettype wire

// File: tb/tb_result_uart_tx.sv
//----------------------------------------------------------------------------
// tb_result_uart_tx : randomized bench with a bit-timing reference model
// Revision 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_result_uart_tx;

   localparam int BAUD = 8;

   logic        clk;
   logic        rst_n;
   logic [1:0]  v;
   logic [41:0] wd [2];
   logic [1:0]  dout, rdy, busy, done;

   int n_cmp = 0;
   int n_err = 0;

   // Instance 1 sends the sync byte, instance 0 does not.
   result_uart_tx #(.BAUD(BAUD), .SYNC_EN(1'b1), .SYNC_BYTE(8'hA5)) u_dut_sync (
      .clk(clk), .rst_n(rst_n), .tx_word_valid(v[1]), .tx_word(wd[1]),
      .tx_word_ready(rdy[1]), .tx_dout(dout[1]), .tx_busy(busy[1]), .tx_word_done(done[1])
   );

   result_uart_tx #(.BAUD(BAUD), .SYNC_EN(1'b0), .SYNC_BYTE(8'hA5)) u_dut_nosync (
      .clk(clk), .rst_n(rst_n), .tx_word_valid(v[0]), .tx_word(wd[0]),
      .tx_word_ready(rdy[0]), .tx_dout(dout[0]), .tx_busy(busy[0]), .tx_word_done(done[0])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [41:0] rnd42();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[41:0];
   endfunction

   // Byte i of the transmitted sequence for a given word.
   function automatic logic [7:0] get_byte(input logic [41:0] w, input bit sync, input int i);
      logic [63:0] t;
      int j;
      j = i;
      if (sync) begin
         if (i == 0) return 8'hA5;
         j = i - 1;
      end
      t = {22'b0, w} >> (8 * j);
      return t[7:0];
   endfunction

   // Expected line level k cycles after the acceptance edge.
   function automatic logic exp_line(input logic [41:0] w, input bit sync, input int k);
      int b, i, p;
      logic [7:0] by;
      b  = k / BAUD;
      i  = b / 10;
      p  = b % 10;
      by = get_byte(w, sync, i);
      if (p == 0) return 1'b0;
      if (p == 9) return 1'b1;
      return by[p-1];
   endfunction

   task automatic check_idle(input int sel, input string tag);
      check_eq({tag, "_dout"}, 64'(dout[sel]), 64'd1);
      check_eq({tag, "_busy"}, 64'(busy[sel]), 64'd0);
      check_eq({tag, "_rdy"},  64'(rdy[sel]),  64'd1);
      check_eq({tag, "_done"}, 64'(done[sel]), 64'd0);
   endtask

   // Called at posedge+1. Sends one word and checks every cycle against the model.
   task automatic run_word(input int sel, input logic [41:0] w, input bit already,
                           input bit keep, input logic [41:0] next_w,
                           input int pulse_at, input int abort_at);
      bit   sync;
      int   nbytes, nb;
      logic bits [0:69];
      logic [7:0] dec;
      sync   = (sel == 1);
      nbytes = sync ? 7 : 6;
      nb     = nbytes * 10 * BAUD;
      if (!already) begin
         v[sel]  = 1'b1;
         wd[sel] = w;
      end
      @(posedge clk); #1;
      check_eq("acc_dout", 64'(dout[sel]), 64'd0);
      check_eq("acc_rdy",  64'(rdy[sel]),  64'd0);
      check_eq("acc_busy", 64'(busy[sel]), 64'd1);
      check_eq("acc_done", 64'(done[sel]), 64'd0);
      v[sel]  = keep;
      wd[sel] = keep ? next_w : rnd42();
      for (int k = 1; k < nb; k++) begin
         @(posedge clk); #1;
         check_eq("line", 64'(dout[sel]), 64'(exp_line(w, sync, k)));
         check_eq("busy_rdy_done", {61'b0, busy[sel], rdy[sel], done[sel]}, 64'b100);
         if (k % BAUD == BAUD / 2) bits[k / BAUD] = dout[sel];
         if (k == pulse_at) begin
            v[sel]  = 1'b1;
            wd[sel] = rnd42();
         end
         if (k == pulse_at + 1) v[sel] = 1'b0;
         if (k == abort_at) begin
            #2 rst_n = 1'b0;
            #1;
            check_eq("abort_dout", 64'(dout[sel]), 64'd1);
            check_eq("abort_busy", 64'(busy[sel]), 64'd0);
            check_eq("abort_rdy",  64'(rdy[sel]),  64'd0);
            check_eq("abort_done", 64'(done[sel]), 64'd0);
            return;
         end
      end
      @(posedge clk); #1;
      check_eq("end_dout", 64'(dout[sel]), 64'd1);
      check_eq("end_rdy",  64'(rdy[sel]),  64'd1);
      check_eq("end_busy", 64'(busy[sel]), 64'd0);
      check_eq("end_done", 64'(done[sel]), 64'd1);
      for (int i = 0; i < nbytes; i++) begin
         for (int b = 0; b < 8; b++) dec[b] = bits[i*10 + 1 + b];
         check_eq("start_bit", 64'(bits[i*10]), 64'd0);
         check_eq("stop_bit",  64'(bits[i*10 + 9]), 64'd1);
         check_eq("byte", 64'(dec), 64'(get_byte(w, sync, i)));
      end
      if (!keep) begin
         @(posedge clk); #1;
         check_idle(sel, "post");
      end
   endtask

   initial begin
      logic [41:0] wa, wb;
      logic [7:0]  ref_bytes [7];
      rst_n = 1'b0;
      v     = 2'b00;
      wd[0] = rnd42();
      wd[1] = rnd42();
      repeat (3) @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         check_eq("rst_dout", 64'(dout[s]), 64'd1);
         check_eq("rst_rdy",  64'(rdy[s]),  64'd0);
         check_eq("rst_busy", 64'(busy[s]), 64'd0);
         check_eq("rst_done", 64'(done[s]), 64'd0);
      end
      rst_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         check_idle(0, "idle0");
         check_idle(1, "idle1");
      end

      // Known vector: the model's byte list must match the hand-decoded bytes.
      ref_bytes = '{8'hA5, 8'h2B, 8'h69, 8'h5F, 8'h4B, 8'h6B, 8'h02};
      for (int i = 0; i < 7; i++)
         check_eq("ref_byte", 64'(get_byte(42'h26B4B5F692B, 1'b1, i)), 64'(ref_bytes[i]));
      run_word(1, 42'h26B4B5F692B, 1'b0, 1'b0, '0, -1, -1);
      check_eq("nosync_b5", 64'(get_byte(~42'h26B6B4F692B, 1'b0, 5)), 64'h01);
      run_word(0, ~42'h26B6B4F692B, 1'b0, 1'b0, '0, -1, -1);

      // Back-to-back words with valid held high.
      wa = rnd42();
      wb = rnd42();
      run_word(1, wa, 1'b0, 1'b1, wb, -1, -1);
      run_word(1, wb, 1'b1, 1'b0, '0, -1, -1);
      wa = rnd42();
      wb = rnd42();
      run_word(0, wa, 1'b0, 1'b1, wb, -1, -1);
      run_word(0, wb, 1'b1, 1'b0, '0, -1, -1);

      // Valid pulse while busy, mid byte 3.
      run_word(1, rnd42(), 1'b0, 1'b0, '0, (3*10 + 3) * BAUD, -1);
      for (int c = 0; c < 3 * BAUD; c++) begin
         @(posedge clk); #1;
         check_idle(1, "no_second");
      end

      for (int r = 0; r < 4; r++)
         run_word(r % 2, rnd42(), 1'b0, 1'b0, '0, -1, -1);

      // Reset during data bit 4 of byte 2.
      run_word(1, rnd42(), 1'b0, 1'b0, '0, -1, (2*10 + 1 + 4) * BAUD + 3);
      v = 2'b00;
      repeat (2) @(posedge clk);
      #1;
      check_eq("abort_hold_dout", 64'(dout[1]), 64'd1);
      check_eq("abort_hold_rdy",  64'(rdy[1]),  64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_idle(1, "rerel1");
      check_idle(0, "rerel0");
      run_word(1, rnd42(), 1'b0, 1'b0, '0, -1, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
